cache_lru: RTL and testbench
============================

# cache_lru

Per-set true-LRU replacement tracker for set-associative caches. It is instantiated by the instruction cache and data cache controllers. It keeps an age rank for every way of every set and returns the least-recently-used way of the queried set as the eviction victim. It also updates the ranks whenever the cache reports a hit or a line fill.

## Interface
Parameters:
- NUM_SET, default 4: number of sets; must be ≥1.
- NUM_WAYS, default 16: total ways in the cache; must equal NUM_SET*WAYS_PER_SET.
- WAYS_PER_SET, default 4: associativity; must be a power of two and ≥2.

Derived widths:
- SW = max(1, $clog2(NUM_SET)).
- WW = $clog2(WAYS_PER_SET).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; restores the reset ranking in every set.
- victim_req  in  1  victim lookup request.
- victim_set  in  SW  set being looked up.
- victim_way  out  WW  LRU way of victim_set; combinational.
- update_req  in  1  mark one way as most-recently-used.
- update_set  in  SW  set to update.
- update_way  in  WW  way to promote to MRU.

## Operation
- State: one WW-bit age per way, NUM_WAYS entries in total. In each set the ages are always a permutation of 0..WAYS_PER_SET-1.
  - Age 0 = MRU.
  - Age WAYS_PER_SET-1 = LRU.
- Reset value: in every set, way w has age WAYS_PER_SET-1-w. This makes way 0 the first victim, so an empty set fills in order 0,1,2,...
- Victim selection:
  - When victim_req=1, victim_way is the way in victim_set whose age is WAYS_PER_SET-1.
  - The permutation invariant guarantees exactly one such way. As a defensive rule, the lowest index wins if more than one matches.
  - When victim_req=0, victim_way=0.
- Update, when update_req=1:
  - In update_set, let A be the current age of update_way.
  - Every way in that set with age < A increments by 1.
  - update_way's age becomes 0.
  - Ways with age > A are unchanged, and other sets are untouched.
  - Updating a way that is already MRU (A=0) leaves the set unchanged.
- The update is the same whether it comes from a hit or a fill; the caller muxes the set and way.

## Timing
- victim_way is purely combinational from the age registers and victim_set/victim_req. It has zero-cycle latency and no handshake.
- An update is written at the rising edge where update_req=1. It becomes visible to victim_way starting the following cycle.
- Simultaneous victim_req and update_req on the same set: victim_way reflects the pre-update ages for that cycle.
- Back-to-back updates, one per cycle and to any sets, are all honored. There is no throughput limit.
- Reset asserted mid-operation clears all ages immediately, without waiting for an edge. With victim_req=1, victim_way reads 0 while reset is held and after release until the first update.
- During reset, update_req is ignored.

## Structure
- No shared-package typedefs are required. The address-range macros (set/way widths) used by the callers stay in the SoC header.
- A natural sub-module is lru_set_ages: one instance per set via generate. It holds WAYS_PER_SET ages and provides the increment/promote logic and the LRU-way encoder.
- The top level decodes update_set into per-set enables and muxes victim_way by victim_set.

## Test plan
Use defaults (NUM_SET=4, WAYS_PER_SET=4) unless noted.

1. After reset, victim_req=1 on sets 0..3: victim_way=0 for every set.
2. Set 1: update ways 0,1,2,3 on consecutive cycles. Victim after each update is 1,2,3,0; the fill order wraps.
3. From reset, update set 0 way 2. Ages become 3,2,0,1; victim stays 0. Then update way 0: victim=1.
4. Update set 2 way 0 and victim_req on set 2 in the same cycle: victim_way=0 in that cycle and 1 the next cycle. Sets 0, 1 and 3 are still at victim 0.
5. Update the same way twice in a row (set 3, way 3 twice): the ranking is unchanged after the second update; victim=0.
6. Perform updates on several sets, then assert reset asynchronously (not aligned to a clock edge): all victims return to 0 immediately, and no update issued during reset takes effect.

Source files
------------

// File: rtl/cache_lru_pkg.sv
// ---------------------------------------------------------------------------
// cache_lru_pkg
// Shared helpers for the true-LRU replacement tracker:
//   sel_width - width of a set index (at least one bit, even for one set)
//   init_age  - age a way takes at reset (way 0 oldest, last way youngest)
//   cfg_ok    - checks that the cache geometry parameters are consistent
// ---------------------------------------------------------------------------
package cache_lru_pkg;

  // Index width for n items; a single item still needs a one-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Reset ranking: way w gets age (ways-1-w), so way 0 is the first victim
  // and an empty set fills in ascending way order.
  function automatic int unsigned init_age(input int unsigned way,
                                           input int unsigned ways);
    return ways - 32'd1 - way;
  endfunction

  // Geometry sanity: at least one set, power-of-two associativity >= 2,
  // and the total way count matching sets * ways-per-set.
  function automatic bit cfg_ok(input int unsigned num_set,
                                input int unsigned num_ways,
                                input int unsigned ways_per_set);
    bit ok;
    ok = 1'b1;
    if (num_set < 32'd1) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if ((ways_per_set < 32'd2) || ((ways_per_set & (ways_per_set - 32'd1)) != 32'd0)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if (num_ways != (num_set * ways_per_set)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

endpackage

// File: rtl/cache_lru_set_ages.sv
// ---------------------------------------------------------------------------
// cache_lru_set_ages
// Age ranking for the ways of one cache set. Ages form a permutation of
// 0..WAYS-1 (0 = most recently used, WAYS-1 = least recently used).
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset to the initial ranking
//   update_en  in   promote update_way to MRU at this edge
//   update_way in   way being promoted
//   lru_way    out  way currently holding the oldest age (combinational)
// ---------------------------------------------------------------------------
module cache_lru_set_ages
  import cache_lru_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int WW   = $clog2(WAYS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          update_en,
  input  logic [WW-1:0] update_way,
  output logic [WW-1:0] lru_way
);

  logic [WAYS-1:0][WW-1:0] ages_r;
  logic [WAYS-1:0][WW-1:0] ages_next_s;
  logic [WW-1:0]           promote_age_s;
  logic                    lru_found_s;

  // Next-state ranking: everything younger than the promoted way ages by
  // one, the promoted way becomes age 0, older ways keep their age. When the
  // promoted way is already MRU no other way is younger, so nothing moves.
  always_comb begin
    promote_age_s = ages_r[update_way];
    ages_next_s   = ages_r;
    for (int w = 0; w < WAYS; w++) begin
      if (update_en) begin
        if (update_way == WW'(w)) begin
          ages_next_s[w] = {WW{1'b0}};
        end else if (ages_r[w] < promote_age_s) begin
          ages_next_s[w] = ages_r[w] + WW'(1);
        end else begin
          ages_next_s[w] = ages_r[w];
        end
      end else begin
        ages_next_s[w] = ages_r[w];
      end
    end
  end

  // Age registers; reset takes effect immediately and blocks any update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) begin
        ages_r[w] <= WW'(init_age(w, WAYS));
      end
    end else begin
      ages_r <= ages_next_s;
    end
  end

  // LRU encoder: first way holding the oldest age. The ranking is always a
  // permutation so exactly one way matches; lowest index wins defensively.
  always_comb begin
    lru_way     = {WW{1'b0}};
    lru_found_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lru_found_s && (ages_r[w] == WW'(WAYS - 1))) begin
        lru_way     = WW'(w);
        lru_found_s = 1'b1;
      end else begin
        lru_found_s = lru_found_s;
      end
    end
  end

endmodule

// File: rtl/cache_lru.sv
// ---------------------------------------------------------------------------
// cache_lru
// Per-set true-LRU replacement tracker. Holds an age ranking for every way
// of every set, reports the LRU way of a queried set as eviction victim and
// promotes a way to MRU on every hit or fill reported by the cache.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high; restores the reset ranking
//   victim_req  in   victim lookup request
//   victim_set  in   set being looked up
//   victim_way  out  LRU way of victim_set (combinational, 0 when idle)
//   update_req  in   promote one way to MRU at this edge
//   update_set  in   set to update
//   update_way  in   way to promote
// ---------------------------------------------------------------------------
module cache_lru
  import cache_lru_pkg::*;
#(
  parameter int NUM_SET      = 4,
  parameter int NUM_WAYS     = 16,
  parameter int WAYS_PER_SET = 4,
  parameter int SW           = sel_width(NUM_SET),
  parameter int WW           = $clog2(WAYS_PER_SET)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          victim_req,
  input  logic [SW-1:0] victim_set,
  output logic [WW-1:0] victim_way,
  input  logic          update_req,
  input  logic [SW-1:0] update_set,
  input  logic [WW-1:0] update_way
);

  logic [WW-1:0] lru_s [NUM_SET];
  logic          upd_en_s [NUM_SET];
  logic [WW-1:0] victim_sel_s;

  if (!cfg_ok(NUM_SET, NUM_WAYS, WAYS_PER_SET)) begin : g_bad_cfg
    $error("cache_lru: inconsistent NUM_SET/NUM_WAYS/WAYS_PER_SET");
  end

  // One ranking per set; update_set is decoded into per-set enables so only
  // the addressed set moves. Indices beyond NUM_SET-1 match no set.
  for (genvar s = 0; s < NUM_SET; s++) begin : g_set
    assign upd_en_s[s] = update_req && (update_set == SW'(s));

    cache_lru_set_ages #(
      .WAYS (WAYS_PER_SET),
      .WW   (WW)
    ) u_ages (
      .clock      (clock),
      .reset      (reset),
      .update_en  (upd_en_s[s]),
      .update_way (update_way),
      .lru_way    (lru_s[s])
    );
  end

  // Victim mux: pick the queried set's LRU way, forced to 0 when no lookup.
  always_comb begin
    victim_sel_s = {WW{1'b0}};
    for (int s = 0; s < NUM_SET; s++) begin
      if (victim_set == SW'(s)) begin
        victim_sel_s = lru_s[s];
      end else begin
        victim_sel_s = victim_sel_s;
      end
    end
    if (victim_req) begin
      victim_way = victim_sel_s;
    end else begin
      victim_way = {WW{1'b0}};
    end
  end

endmodule

// File: tb/tb_cache_lru.sv
module tb_cache_lru;

  localparam int NSET = 4;
  localparam int WPS  = 4;
  localparam int SW   = 2;
  localparam int WW   = 2;

  logic          clock;
  logic          reset;
  logic          victim_req;
  logic [SW-1:0] victim_set;
  logic [WW-1:0] victim_way;
  logic          update_req;
  logic [SW-1:0] update_set;
  logic [WW-1:0] update_way;

  int vectors;
  int miscompares;

  // Reference model: for each set, the list of ways ordered from most to
  // least recently used. The victim is the last entry.
  int order_m [NSET][WPS];

  cache_lru #(
    .NUM_SET      (NSET),
    .NUM_WAYS     (NSET * WPS),
    .WAYS_PER_SET (WPS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .victim_req (victim_req),
    .victim_set (victim_set),
    .victim_way (victim_way),
    .update_req (update_req),
    .update_set (update_set),
    .update_way (update_way)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    // Way w starts at age WPS-1-w: the highest way is MRU, way 0 is LRU.
    for (int s = 0; s < NSET; s++)
      for (int i = 0; i < WPS; i++)
        order_m[s][i] = WPS - 1 - i;
  endtask

  task automatic model_touch(input int s, input int way);
    int pos;
    pos = 0;
    for (int i = 0; i < WPS; i++)
      if (order_m[s][i] == way) pos = i;
    for (int i = pos; i > 0; i--)
      order_m[s][i] = order_m[s][i-1];
    order_m[s][0] = way;
  endtask

  function automatic int model_victim(input int s);
    return order_m[s][WPS-1];
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: victim_way observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check the combinational
  // victim (pre-update ranking), then let the rising edge apply the update.
  task automatic step(input bit ureq, input int uset, input int uway,
                      input bit vreq, input int vset, input string tag);
    logic [WW-1:0] exp;
    @(negedge clock);
    update_req = ureq;
    update_set = uset[SW-1:0];
    update_way = uway[WW-1:0];
    victim_req = vreq;
    victim_set = vset[SW-1:0];
    #1;
    exp = vreq ? WW'(model_victim(vset)) : {WW{1'b0}};
    check(tag, victim_way, exp);
    if (ureq && !reset) model_touch(uset, uway);
  endtask

  task automatic check_all_sets(input string tag);
    for (int s = 0; s < NSET; s++) begin
      victim_req = 1'b1;
      victim_set = s[SW-1:0];
      #1;
      check(tag, victim_way, WW'(model_victim(s)));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    update_req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    victim_req  = 1'b0;
    victim_set  = '0;
    update_req  = 1'b0;
    update_set  = '0;
    update_way  = '0;
    model_reset();
    #17 reset = 1'b0;

    // 1: reset ranking makes way 0 the victim of every set.
    check_all_sets("reset_victim");
    step(1'b0, 0, 0, 1'b0, 2, "idle_zero");

    // 2: fill set 1 in order; victim walks 1,2,3 and wraps to 0.
    for (int w = 0; w < WPS; w++)
      step(1'b1, 1, w, 1'b1, 1, "fill_order");
    step(1'b0, 0, 0, 1'b1, 1, "fill_wrap");

    // 3: promote way 2 then way 0 in set 0.
    pulse_reset();
    step(1'b1, 0, 2, 1'b1, 0, "promote_mid");
    step(1'b1, 0, 0, 1'b1, 0, "promote_mid_after");
    step(1'b0, 0, 0, 1'b1, 0, "promote_lru_after");

    // 4: same-cycle lookup and update see the pre-update ranking.
    pulse_reset();
    step(1'b1, 2, 0, 1'b1, 2, "same_cycle_pre");
    step(1'b0, 0, 0, 1'b1, 2, "same_cycle_post");
    check_all_sets("other_sets_intact");

    // 5: promoting the MRU way leaves the ranking unchanged.
    pulse_reset();
    step(1'b1, 3, 3, 1'b1, 3, "mru_twice_1");
    step(1'b1, 3, 3, 1'b1, 3, "mru_twice_2");
    step(1'b0, 0, 0, 1'b1, 3, "mru_twice_after");

    // 6: asynchronous reset mid-cycle, updates ignored while it is held.
    step(1'b1, 0, 0, 1'b0, 0, "pre_rst_a");
    step(1'b1, 1, 0, 1'b0, 0, "pre_rst_b");
    step(1'b1, 2, 1, 1'b1, 0, "pre_rst_c");
    @(negedge clock);
    update_req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    check_all_sets("async_reset");
    step(1'b1, 0, 0, 1'b1, 0, "upd_in_reset_a");
    step(1'b1, 1, 0, 1'b1, 1, "upd_in_reset_b");
    @(negedge clock);
    update_req = 1'b0;
    #2 reset = 1'b0;
    check_all_sets("after_reset_release");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, NSET - 1)),
           int'($urandom_range(0, WPS - 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, NSET - 1)), "random");
    @(negedge clock);
    update_req = 1'b0;
    check_all_sets("random_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
